// File: rtl/djudge_pkg.sv
// Shared types and codes for the double-up judge: FSM states, guess and
// result encodings, and the tie-rule selector values.
package djudge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_JUDGE = 2'd2
  } state_t;

  localparam logic [1:0] GUESS_NONE = 2'b00;
  localparam logic [1:0] GUESS_HIGH = 2'b01;
  localparam logic [1:0] GUESS_LOW  = 2'b10;
  localparam logic [1:0] GUESS_CASH = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_TIE  = 2'b10;
  localparam logic [1:0] RES_LOSE = 2'b11;

  // Tie rule: a push keeps the pot and counts the round; otherwise a tie loses.
  localparam int TIE_PUSH  = 0;
  localparam int TIE_LOSES = 1;

endpackage

// File: rtl/djudge_multi_if.sv
// Bundle between the dealer/controller side (master) and the judge (slave).
interface djudge_multi_if #(
  parameter int CARD_W = 4,
  parameter int PAY_W  = 16,
  parameter int SW     = 2
);
  logic              bet_c;
  logic              start;
  logic [PAY_W-1:0]  stake;
  logic              guess_valid;
  logic [1:0]        guess;
  logic              guess_ready;
  logic [CARD_W-1:0] card_cur;
  logic [CARD_W-1:0] card_next;
  logic              result_valid;
  logic [1:0]        result;
  logic [PAY_W-1:0]  payout;
  logic [SW-1:0]     streak;
  logic              chance;
  logic              done;

  modport master (
    output bet_c, start, stake, guess_valid, guess, card_cur, card_next,
    input  guess_ready, result_valid, result, payout, streak, chance, done
  );

  modport slave (
    input  bet_c, start, stake, guess_valid, guess, card_cur, card_next,
    output guess_ready, result_valid, result, payout, streak, chance, done
  );
endinterface

// File: rtl/djudge_cmp.sv
// Combinational guess judge: maps (guess, shown card, drawn card) to a result
// code. Cash-out and empty guesses map to RES_NONE.
module djudge_cmp
  import djudge_pkg::*;
#(
  parameter int CARD_W   = 4,
  parameter int TIE_MODE = TIE_PUSH
) (
  input  logic [1:0]        guess,
  input  logic [CARD_W-1:0] card_cur,
  input  logic [CARD_W-1:0] card_next,
  output logic [1:0]        result
);

  // Unsigned rank comparison against the direction that was guessed.
  always_comb begin
    result = RES_NONE;
    if (guess == GUESS_HIGH || guess == GUESS_LOW) begin
      if (card_next == card_cur)
        result = (TIE_MODE == TIE_PUSH) ? RES_TIE : RES_LOSE;
      else if ((guess == GUESS_HIGH) == (card_next > card_cur))
        result = RES_WIN;
      else
        result = RES_LOSE;
    end
  end

endmodule

// File: rtl/djudge_multi.sv
// Double-up judge: opens a game with a stake, accepts high/low/cash-out
// guesses, doubles (saturating) or clears the pot, counts the streak and
// ends the game on loss, cash-out or the round cap.
module djudge_multi
  import djudge_pkg::*;
#(
  parameter int CARD_W     = 4,
  parameter int MAX_ROUNDS = 3,
  parameter int PAY_W      = 16,
  parameter int TIE_MODE   = TIE_PUSH
) (
  input logic          clock,
  input logic          reset_c,
  djudge_multi_if.slave bus
);

  localparam int SW = $clog2(MAX_ROUNDS + 1);
  localparam logic [SW-1:0] MAX_STREAK = SW'(MAX_ROUNDS);

  state_t            state_reg, state_next;
  logic [PAY_W-1:0]  payout_reg, payout_next;
  logic [SW-1:0]     streak_reg, streak_next;
  logic              chance_reg, chance_next;
  logic [1:0]        result_reg, result_next;
  logic              result_valid_reg, result_valid_next;
  logic              done_reg, done_next;
  logic [1:0]        guess_reg, guess_next;
  logic [CARD_W-1:0] cur_card_reg, cur_card_next;
  logic [CARD_W-1:0] nxt_card_reg, nxt_card_next;

  logic [1:0]        cmp_result;
  logic [PAY_W-1:0]  pot_double;
  logic [SW-1:0]     streak_inc;

  djudge_cmp #(
    .CARD_W   (CARD_W),
    .TIE_MODE (TIE_MODE)
  ) u_cmp (
    .guess     (guess_reg),
    .card_cur  (cur_card_reg),
    .card_next (nxt_card_reg),
    .result    (cmp_result)
  );

  // Doubling saturates to all-ones when the top bit would be shifted out.
  assign pot_double = payout_reg[PAY_W-1] ? '1 : {payout_reg[PAY_W-2:0], 1'b0};
  assign streak_inc = streak_reg + 1'b1;

  // Next-state and output decisions; abort via bet_c outranks everything.
  always_comb begin
    state_next        = state_reg;
    payout_next       = payout_reg;
    streak_next       = streak_reg;
    chance_next       = chance_reg;
    result_next       = result_reg;
    result_valid_next = 1'b0;
    done_next         = 1'b0;
    guess_next        = guess_reg;
    cur_card_next     = cur_card_reg;
    nxt_card_next     = nxt_card_reg;

    if (!bus.bet_c) begin
      state_next  = ST_IDLE;
      payout_next = '0;
      streak_next = '0;
      chance_next = 1'b0;
      result_next = RES_NONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start && bus.stake != '0) begin
            payout_next = bus.stake;
            streak_next = '0;
            chance_next = 1'b1;
            result_next = RES_NONE;
            state_next  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.guess_valid && bus.guess != GUESS_NONE) begin
            guess_next    = bus.guess;
            cur_card_next = bus.card_cur;
            nxt_card_next = bus.card_next;
            state_next    = ST_JUDGE;
          end
        end
        ST_JUDGE: begin
          if (guess_reg == GUESS_CASH) begin
            result_next = RES_NONE;
            chance_next = 1'b0;
            done_next   = 1'b1;
            state_next  = ST_IDLE;
          end else if (cmp_result == RES_WIN || cmp_result == RES_TIE) begin
            result_next       = cmp_result;
            result_valid_next = 1'b1;
            streak_next       = streak_inc;
            if (cmp_result == RES_WIN)
              payout_next = pot_double;
            if (streak_inc == MAX_STREAK) begin
              chance_next = 1'b0;
              done_next   = 1'b1;
              state_next  = ST_IDLE;
            end else begin
              chance_next = 1'b1;
              state_next  = ST_WAIT;
            end
          end else begin
            result_next       = RES_LOSE;
            result_valid_next = 1'b1;
            payout_next       = '0;
            streak_next       = '0;
            chance_next       = 1'b0;
            done_next         = 1'b1;
            state_next        = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset_c) begin
    if (reset_c) begin
      state_reg        <= ST_IDLE;
      payout_reg       <= '0;
      streak_reg       <= '0;
      chance_reg       <= 1'b0;
      result_reg       <= RES_NONE;
      result_valid_reg <= 1'b0;
      done_reg         <= 1'b0;
      guess_reg        <= GUESS_NONE;
      cur_card_reg     <= '0;
      nxt_card_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      payout_reg       <= payout_next;
      streak_reg       <= streak_next;
      chance_reg       <= chance_next;
      result_reg       <= result_next;
      result_valid_reg <= result_valid_next;
      done_reg         <= done_next;
      guess_reg        <= guess_next;
      cur_card_reg     <= cur_card_next;
      nxt_card_reg     <= nxt_card_next;
    end
  end

  assign bus.guess_ready  = (state_reg == ST_WAIT);
  assign bus.result_valid = result_valid_reg;
  assign bus.result       = result_reg;
  assign bus.payout       = payout_reg;
  assign bus.streak       = streak_reg;
  assign bus.chance       = chance_reg;
  assign bus.done         = done_reg;

endmodule
